vm3_irq_arbiter: RTL and testbench

//   Vectored interrupt arbiter that feeds the processor board's interrupt interface
//   (irq_i[5:4] / istb_o[5:4] / ivec / iack_i). Collects requests from NSRC

---
 rtl/vm3_irq_arbiter.sv | 153 +++++++++++++++
 tb/tb_vm3_irq_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm3_irq_arbiter.sv
// Two-level (5/4) vectored interrupt arbiter between NSRC peripherals and the CPU board.
// Define IRQ_ROUNDROBIN_EN for rotating priority per level; default is fixed lowest-index priority.
module vm3_irq_arbiter #(
  parameter int               NSRC      = 8,
  parameter logic [NSRC-1:0]  LVL5_MASK = NSRC'(8'h0F),
  parameter logic [8:0]       SPUR_VEC  = 9'o000
) (
  input  logic                clk_p,
  input  logic                rst_n,
  input  logic                bus_reset,
  input  logic [NSRC-1:0]     src_req,
  input  logic [9*NSRC-1:0]   src_vec,
  output logic [NSRC-1:0]     src_iack,
  output logic [5:4]          irq_o,
  input  logic [5:4]          istb_i,
  output logic [8:0]          ivec_o,
  output logic                iack_o
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {IDLE, SEL, ACK, DONE} state_t;

  state_t          state;
  logic            lvl5_q;
  logic [IW-1:0]   win_idx;
  logic            spur_q;
  logic [IW-1:0]   ptr5;
  logic [IW-1:0]   ptr4;

  logic [NSRC-1:0] m5;
  logic [NSRC-1:0] m4;
  logic            sel_l5;
  logic [NSRC-1:0] sel_m;
  logic [IW-1:0]   sel_idx;
  logic            sel_any;
  logic [8:0]      sel_vec;
  logic            stb_lvl;
  logic [NSRC-1:0] excl;
  logic [5:4]      irq_next;

  // First requesting index at or after start, wrapping NSRC-1 -> 0.
  function automatic logic [IW-1:0] pick(input logic [NSRC-1:0] m, input logic [IW-1:0] start);
    logic [IW-1:0] r;
    logic          found;
    int            idx;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      idx = int'(start) + i;
      if (idx >= NSRC) idx = idx - NSRC;
      if (!found && m[idx]) begin
        r     = IW'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

`ifndef IRQ_ROUNDROBIN_EN
  assign ptr5 = '0;
  assign ptr4 = '0;
`endif

  // NOTE: every always_comb output is assigned on every path (excl defaults first) so no latch is inferred.
  always_comb begin
    m5       = src_req & LVL5_MASK;
    m4       = src_req & ~LVL5_MASK;
    sel_l5   = (state == IDLE) ? istb_i[5] : lvl5_q;
    sel_m    = sel_l5 ? m5 : m4;
    sel_idx  = pick(sel_m, sel_l5 ? ptr5 : ptr4);
    sel_any  = |sel_m;
    sel_vec  = src_vec[9*sel_idx +: 9];
    stb_lvl  = lvl5_q ? istb_i[5] : istb_i[4];
    // Hide the request being served so the CPU cannot take it a second time.
    excl = '0;
    case (state)
      IDLE:    if ((|istb_i) && sel_any) excl = NSRC'(1) << sel_idx;
      SEL:     if (sel_any) excl = NSRC'(1) << sel_idx;
      ACK:     if (!spur_q) excl = NSRC'(1) << win_idx;
      default: excl = '0;
    endcase
    irq_next = {|(m5 & ~excl), |(m4 & ~excl)};
  end

  // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lvl5_q   <= 1'b0;
      win_idx  <= '0;
      spur_q   <= 1'b0;
      src_iack <= '0;
      irq_o    <= '0;
      ivec_o   <= '0;
      iack_o   <= 1'b0;
`ifdef IRQ_ROUNDROBIN_EN
      ptr5     <= '0;
      ptr4     <= '0;
`endif
    end else if (bus_reset) begin
      state    <= IDLE;
      lvl5_q   <= 1'b0;
      win_idx  <= '0;
      spur_q   <= 1'b0;
      src_iack <= '0;
      irq_o    <= '0;
      ivec_o   <= '0;
      iack_o   <= 1'b0;
`ifdef IRQ_ROUNDROBIN_EN
      ptr5     <= '0;
      ptr4     <= '0;
`endif
    end else begin
      src_iack <= '0;
      irq_o    <= irq_next;
      case (state)
        IDLE: begin
          if (|istb_i) begin
            lvl5_q <= istb_i[5];
            state  <= SEL;
          end
        end
        SEL: begin
          win_idx <= sel_idx;
          spur_q  <= !sel_any;
          ivec_o  <= sel_any ? sel_vec : SPUR_VEC;
          iack_o  <= 1'b1;
          state   <= ACK;
        end
        ACK: begin
          if (!stb_lvl) begin
            iack_o <= 1'b0;
            ivec_o <= '0;
            if (!spur_q) src_iack <= NSRC'(1) << win_idx;
            state  <= DONE;
          end
        end
        DONE: begin
`ifdef IRQ_ROUNDROBIN_EN
          if (!spur_q) begin
            if (lvl5_q) ptr5 <= (win_idx == IW'(NSRC-1)) ? '0 : win_idx + 1'b1;
            else        ptr4 <= (win_idx == IW'(NSRC-1)) ? '0 : win_idx + 1'b1;
          end
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vm3_irq_arbiter.sv
// Self-checking bench for vm3_irq_arbiter: directed scenarios plus randomized transactions
// compared against a transaction-level priority model (fixed or round-robin per IRQ_ROUNDROBIN_EN).
module tb_vm3_irq_arbiter;

  localparam int         NSRC  = 8;
  localparam logic [7:0] MASK5 = 8'h0F;
  localparam logic [8:0] SPUR  = 9'o774;

  logic        clk_p     = 1'b0;
  logic        rst_n     = 1'b0;
  logic        bus_reset = 1'b0;
  logic [7:0]  src_req   = '0;
  logic [71:0] src_vec   = '0;
  logic [7:0]  src_iack;
  logic [5:4]  irq_o;
  logic [5:4]  istb_i    = '0;
  logic [8:0]  ivec_o;
  logic        iack_o;

  int errors = 0;
  int checks = 0;
  int ptr5   = 0;
  int ptr4   = 0;

  vm3_irq_arbiter #(.NSRC(NSRC), .LVL5_MASK(MASK5), .SPUR_VEC(SPUR)) dut (
    .clk_p(clk_p), .rst_n(rst_n), .bus_reset(bus_reset),
    .src_req(src_req), .src_vec(src_vec), .src_iack(src_iack),
    .irq_o(irq_o), .istb_i(istb_i), .ivec_o(ivec_o), .iack_o(iack_o)
  );

  always #5 clk_p = ~clk_p;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic set_vec(input int k, input logic [8:0] v);
    src_vec[9*k +: 9] = v;
  endtask

  // Which source the CPU should receive: scan this level's requesters starting at the pointer.
  function automatic int model_winner(input logic [7:0] req, input bit l5, input int start);
    for (int i = 0; i < NSRC; i++) begin
      int k;
      k = (start + i) % NSRC;
      if (req[k] && (MASK5[k] == l5)) return k;
    end
    return -1;
  endfunction

  // One complete interrupt cycle: strobe, vector read, strobe release, device acknowledge.
  // hold < 0 drops the strobe while the arbiter is still selecting.
  task automatic run_irq(input logic [5:4] stb, input int hold, input string tag, output logic [7:0] seen);
    bit         l5;
    int         w;
    logic [8:0] ev;
    logic [7:0] eoh;
    logic [5:4] eirq;
    l5  = stb[5];
    w   = model_winner(src_req, l5, l5 ? ptr5 : ptr4);
    ev  = (w < 0) ? SPUR : src_vec[9*w +: 9];
    eoh = (w < 0) ? 8'h00 : (8'h01 << w);

    tick();
    eirq[5] = |(src_req & MASK5);
    eirq[4] = |(src_req & ~MASK5);
    checks++;
    if (irq_o !== eirq) begin
      errors++; $display("FAIL %s irq_before_strobe: got %b want %b", tag, irq_o, eirq);
    end

    istb_i = stb;
    tick();
    if (hold < 0) istb_i = 2'b00;
    tick();
    eirq[5] = |(src_req & MASK5 & ~eoh);
    eirq[4] = |(src_req & ~MASK5 & ~eoh);
    checks++;
    if (iack_o !== 1'b1) begin
      errors++; $display("FAIL %s iack_two_clocks_after_strobe: got %b want 1", tag, iack_o);
    end
    checks++;
    if (ivec_o !== ev) begin
      errors++; $display("FAIL %s ivec: got %o want %o", tag, ivec_o, ev);
    end
    checks++;
    if (irq_o !== eirq) begin
      errors++; $display("FAIL %s irq_winner_masked: got %b want %b", tag, irq_o, eirq);
    end

    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (iack_o !== 1'b1 || ivec_o !== ev) begin
        errors++; $display("FAIL %s ack_hold: got iack=%b ivec=%o want iack=1 ivec=%o", tag, iack_o, ivec_o, ev);
      end
    end

    istb_i = 2'b00;
    tick();
    checks++;
    if (src_iack !== eoh) begin
      errors++; $display("FAIL %s src_iack_pulse: got %h want %h", tag, src_iack, eoh);
    end
    checks++;
    if (iack_o !== 1'b0 || ivec_o !== 9'o000) begin
      errors++; $display("FAIL %s done_outputs: got iack=%b ivec=%o want 0/0", tag, iack_o, ivec_o);
    end
    seen = src_iack;

    tick();
    checks++;
    if (src_iack !== 8'h00) begin
      errors++; $display("FAIL %s src_iack_single_cycle: got %h want 00", tag, src_iack);
    end

`ifdef IRQ_ROUNDROBIN_EN
    if (w >= 0) begin
      if (l5) ptr5 = (w + 1) % NSRC;
      else    ptr4 = (w + 1) % NSRC;
    end
`endif
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    src_req = 8'hFF;
    for (int k = 0; k < NSRC; k++) set_vec(k, 9'($urandom));
    repeat (3) tick();
    checks++;
    if (irq_o !== 2'b00) begin errors++; $display("FAIL reset_irq: got %b want 00", irq_o); end
    checks++;
    if (iack_o !== 1'b0) begin errors++; $display("FAIL reset_iack: got %b want 0", iack_o); end
    checks++;
    if (ivec_o !== 9'o000) begin errors++; $display("FAIL reset_ivec: got %o want 000", ivec_o); end
    checks++;
    if (src_iack !== 8'h00) begin errors++; $display("FAIL reset_src_iack: got %h want 00", src_iack); end
    src_req = 8'h00;
    rst_n   = 1'b1;
    ptr5 = 0;
    ptr4 = 0;
    tick();
  endtask

  task automatic test_single_source();
    logic [7:0] seen;
    set_vec(2, 9'o060);
    src_req = 8'h04;
    run_irq(2'b10, 1, "single", seen);
    checks++;
    if (seen !== 8'h04) begin errors++; $display("FAIL single_winner: got %h want 04", seen); end
    src_req = 8'h00;
  endtask

  task automatic test_level_priority();
    logic [7:0] seen;
    set_vec(1, 9'o070);
    set_vec(5, 9'o300);
    src_req = 8'h22;
    run_irq(2'b11, 0, "lvl_both", seen);
    checks++;
    if (seen !== 8'h02) begin errors++; $display("FAIL lvl5_beats_lvl4: got %h want 02", seen); end
    run_irq(2'b01, 0, "lvl4", seen);
    checks++;
    if (seen !== 8'h20) begin errors++; $display("FAIL lvl4_second: got %h want 20", seen); end
    src_req = 8'h00;
  endtask

  task automatic test_spurious();
    logic [7:0] seen;
    src_req = 8'h00;
    run_irq(2'b01, 0, "spur", seen);
    src_req = 8'hF0;
    run_irq(2'b10, -1, "spur_short_strobe", seen);
    src_req = 8'h00;
  endtask

  task automatic test_reset_mid_op();
    set_vec(3, 9'o123);
    src_req = 8'h08;
    tick();
    istb_i = 2'b10;
    tick();
    tick();
    checks++;
    if (iack_o !== 1'b1) begin errors++; $display("FAIL busrst_reach_ack: got %b want 1", iack_o); end
    bus_reset = 1'b1;
    tick();
    checks++;
    if (iack_o !== 1'b0 || ivec_o !== 9'o000 || src_iack !== 8'h00 || irq_o !== 2'b00) begin
      errors++;
      $display("FAIL busrst_clear: got iack=%b ivec=%o src_iack=%h irq=%b want all 0", iack_o, ivec_o, src_iack, irq_o);
    end
    bus_reset = 1'b0;
    istb_i    = 2'b00;
    ptr5 = 0;
    ptr4 = 0;
    repeat (2) begin
      tick();
      checks++;
      if (src_iack !== 8'h00 || iack_o !== 1'b0) begin
        errors++; $display("FAIL busrst_no_pulse: got src_iack=%h iack=%b want 00/0", src_iack, iack_o);
      end
    end

    // Asynchronous reset must clear outputs without waiting for a clock edge.
    istb_i = 2'b10;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (iack_o !== 1'b0 || ivec_o !== 9'o000) begin
      errors++; $display("FAIL async_reset: got iack=%b ivec=%o want 0/000", iack_o, ivec_o);
    end
    istb_i  = 2'b00;
    src_req = 8'h00;
    tick();
    rst_n = 1'b1;
    ptr5 = 0;
    ptr4 = 0;
    tick();
  endtask

  task automatic test_within_level();
    logic [7:0] seen;
    logic [7:0] exp_seq [3];
`ifdef IRQ_ROUNDROBIN_EN
    exp_seq = '{8'h01, 8'h08, 8'h01};
`else
    exp_seq = '{8'h01, 8'h01, 8'h01};
`endif
    set_vec(0, 9'o100);
    set_vec(3, 9'o104);
    src_req = 8'h09;
    for (int i = 0; i < 3; i++) begin
      run_irq(2'b10, 0, "within_lvl", seen);
      checks++;
      if (seen !== exp_seq[i]) begin
        errors++; $display("FAIL within_lvl_winner%0d: got %h want %h", i, seen, exp_seq[i]);
      end
    end
    src_req = 8'h00;
  endtask

  task automatic test_random();
    logic [7:0] seen;
    logic [1:0] r;
    int         hold;
    for (int n = 0; n < 40; n++) begin
      src_req = 8'($urandom);
      for (int k = 0; k < NSRC; k++) set_vec(k, 9'($urandom));
      r    = 2'($urandom_range(1, 3));
      hold = int'($urandom_range(0, 3)) - 1;
      run_irq(r, hold, "random", seen);
    end
    src_req = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_level_priority();
    test_spurious();
    test_reset_mid_op();
    test_within_level();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
